// File: rtl/camera_step_ctrl.sv
// camera_step_ctrl: frame-synchronous sequencer for the virtual camera's
// one-cycle step_left/step_right inputs. It arbitrates manual buttons
// (tap plus hold-to-repeat), timed auto-rotate and shortest-path homing.
// It also keeps a shadow of the 6-bit camera offset.
// Optional build macro: CAM_AUTO_PINGPONG_EN. When defined, auto-rotate
// sweeps back and forth over offsets 0..32 instead of spinning right.
module camera_step_ctrl #(
  parameter int HOLD_FRAMES   = 30,
  parameter int REPEAT_FRAMES = 4,
  parameter int AUTO_FRAMES   = 2,
  parameter int TICK_W        = 6
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       auto_en,
  input  logic       home,
  output logic       step_left,
  output logic       step_right,
  output logic [5:0] cam_offset,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_PRESS  = 3'd1,
    S_HOLD   = 3'd2,
    S_REPEAT = 3'd3,
    S_AUTO   = 3'd4,
    S_HOME   = 3'd5
  } state_t;

  localparam logic [TICK_W-1:0] HOLD_T   = TICK_W'(HOLD_FRAMES);
  localparam logic [TICK_W-1:0] REPEAT_T = TICK_W'(REPEAT_FRAMES);
  localparam logic [TICK_W-1:0] AUTO_T   = TICK_W'(AUTO_FRAMES);

  state_t            st, st_nxt;
  logic [TICK_W-1:0] cnt, cnt_nxt, cnt_inc;
  logic              dir_r, dir_nxt;      // latched press direction, 1 = right
  logic              btn_l_d, btn_r_d;    // previous-cycle button levels
  logic              step_l_nxt, step_r_nxt;
  logic [5:0]        off_eff;
  logic              ev_l, ev_r, both, held;
`ifdef CAM_AUTO_PINGPONG_EN
  logic              pp_right, pp_nxt;    // sweep direction, 1 = right
`endif

  // Offset after applying a (mutually exclusive) right/left step, mod 64.
  function automatic logic [5:0] off_step(input logic [5:0] off,
                                          input logic       r,
                                          input logic       l);
    off_step = off;
    if (r)      off_step = off + 6'd1;
    else if (l) off_step = off - 6'd1;
  endfunction

  // A button event is a fresh rising edge of one button while the other is low.
  assign ev_l    = btn_left  & ~btn_l_d & ~btn_right;
  assign ev_r    = btn_right & ~btn_r_d & ~btn_left;
  assign both    = btn_left & btn_right;
  assign held    = dir_r ? btn_right : btn_left;
  assign cnt_inc = cnt + TICK_W'(1);
  // Offset including the step currently on the wire, so decisions never act
  // on a stale shadow even when frame ticks arrive back to back.
  assign off_eff = off_step(cam_offset, step_right, step_left);
  assign state   = st;

  // Next-state, tick counter and step-request decode.
  always_comb begin
    st_nxt     = st;
    cnt_nxt    = cnt;
    dir_nxt    = dir_r;
    step_l_nxt = 1'b0;
    step_r_nxt = 1'b0;
`ifdef CAM_AUTO_PINGPONG_EN
    pp_nxt     = pp_right;
`endif
    case (st)
      S_IDLE: begin
        if (home) begin
          st_nxt = S_HOME;
        end else if (ev_l || ev_r) begin
          st_nxt  = S_PRESS;
          dir_nxt = ev_r;
        end else if (auto_en && !btn_left && !btn_right) begin
          st_nxt  = S_AUTO;
          cnt_nxt = '0;
`ifdef CAM_AUTO_PINGPONG_EN
          pp_nxt  = 1'b1;
`endif
        end
      end
      S_PRESS: begin
        if (both) begin
          st_nxt = S_IDLE;
        end else if (frame_tick) begin
          step_r_nxt = dir_r;
          step_l_nxt = ~dir_r;
          st_nxt     = S_HOLD;
          cnt_nxt    = '0;
        end
      end
      S_HOLD: begin
        if (both || !held) begin
          st_nxt = S_IDLE;
        end else if (frame_tick) begin
          if (cnt_inc == HOLD_T) begin
            st_nxt  = S_REPEAT;
            cnt_nxt = '0;
          end else begin
            cnt_nxt = cnt_inc;
          end
        end
      end
      S_REPEAT: begin
        if (both || !held) begin
          st_nxt = S_IDLE;
        end else if (frame_tick) begin
          if (cnt_inc == REPEAT_T) begin
            step_r_nxt = dir_r;
            step_l_nxt = ~dir_r;
            cnt_nxt    = '0;
          end else begin
            cnt_nxt = cnt_inc;
          end
        end
      end
      S_AUTO: begin
        if (home) begin
          st_nxt = S_HOME;
        end else if (ev_l || ev_r) begin
          st_nxt  = S_PRESS;
          dir_nxt = ev_r;
        end else if (!auto_en) begin
          st_nxt = S_IDLE;
        end else if (frame_tick) begin
          if (cnt_inc == AUTO_T) begin
            cnt_nxt = '0;
`ifdef CAM_AUTO_PINGPONG_EN
            // At or above 32 head left; at 0 head right; else keep sweeping.
            if (off_eff >= 6'd32) begin
              step_l_nxt = 1'b1;
              pp_nxt     = 1'b0;
            end else if (off_eff == 6'd0) begin
              step_r_nxt = 1'b1;
              pp_nxt     = 1'b1;
            end else begin
              step_r_nxt = pp_right;
              step_l_nxt = ~pp_right;
            end
`else
            step_r_nxt = 1'b1;
`endif
          end else begin
            cnt_nxt = cnt_inc;
          end
        end
      end
      S_HOME: begin
        if (off_eff == 6'd0) begin
          st_nxt = S_IDLE;
        end else if (frame_tick) begin
          // Offsets 32..63 are closer to 0 going right (through the wrap).
          step_r_nxt = off_eff[5];
          step_l_nxt = ~off_eff[5];
        end
      end
      default: st_nxt = S_IDLE;
    endcase
  end

  // State, counter, button history and the registered step/offset outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st         <= S_IDLE;
      cnt        <= '0;
      dir_r      <= 1'b0;
      btn_l_d    <= 1'b0;
      btn_r_d    <= 1'b0;
      step_left  <= 1'b0;
      step_right <= 1'b0;
      cam_offset <= 6'd0;
`ifdef CAM_AUTO_PINGPONG_EN
      pp_right   <= 1'b1;
`endif
    end else begin
      st         <= st_nxt;
      cnt        <= cnt_nxt;
      dir_r      <= dir_nxt;
      btn_l_d    <= btn_left;
      btn_r_d    <= btn_right;
      step_left  <= step_l_nxt;
      step_right <= step_r_nxt;
      cam_offset <= off_eff;
`ifdef CAM_AUTO_PINGPONG_EN
      pp_right   <= pp_nxt;
`endif
    end
  end

endmodule
